// File: rtl/i7748_xor_monitor_if.sv
// Data bundle of the XOR monitor cell: two input code bits and the registered result.
// Latency: not applicable (pure signal grouping).
// Backpressure: none; the cell samples every rising edge and has no ready path.
interface i7748_xor_monitor_if;
   logic N0;
   logic N1;
   logic output_single;

   // Harness side: drives the input code, observes the result.
   modport master (
      output N0,
      output N1,
      input  output_single
   );

   // Cell side: samples the input code, drives the result.
   modport slave (
      input  N0,
      input  N1,
      output output_single
   );
endinterface

// File: rtl/i7748_xor_monitor.sv
// Registered XOR of {N0,N1}; optional sequence monitor (macro I7748_SEQ_MON_EN)
// forces a one-cycle 1 on the output when codes 00,01,10,11 arrive on consecutive edges.
// Latency: one rising CK edge. Backpressure: none, a new code is sampled on every edge.
module i7748_xor_monitor #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic                    CK,
   input  logic                    reset,
   i7748_xor_monitor_if.slave      bus
);

   logic [1:0] code;
   logic       xor_bit;
   logic       hit;
   logic       out_next;

   assign code    = {bus.N0, bus.N1};
   assign xor_bit = bus.N0 ^ bus.N1;

`ifdef I7748_SEQ_MON_EN
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      S1   = 2'd1,
      S2   = 2'd2,
      S3   = 2'd3
   } state_t;

   state_t state;
   state_t state_next;

   // Monitor state register; reset returns to IDLE so a partial sequence is discarded.
   always_ff @(posedge CK or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Sequence tracking: any 00 (re)starts a sequence; a hit always returns to IDLE,
   // so overlapping sequences are never reported.
   always_comb begin
      state_next = IDLE;
      hit        = 1'b0;
      case (state)
         IDLE: begin
            if (code == 2'b00) state_next = S1;
         end
         S1: begin
            if (code == 2'b01)      state_next = S2;
            else if (code == 2'b00) state_next = S1;
         end
         S2: begin
            if (code == 2'b10)      state_next = S3;
            else if (code == 2'b00) state_next = S1;
         end
         S3: begin
            if (code == 2'b11) begin
               state_next = IDLE;
               hit        = 1'b1;
            end else if (code == 2'b00) begin
               state_next = S1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end
`else
   // Without the monitor the output is the plain XOR; the code is only used for it.
   assign hit = 1'b0;
`endif

   assign out_next = xor_bit | hit;

   // Output register: the only path to output_single, so no input-to-output combinational path.
   always_ff @(posedge CK or posedge reset) begin
      if (reset) begin
         bus.output_single <= RESET_VAL;
      end else begin
         bus.output_single <= out_next;
      end
   end

endmodule

// File: tb/tb_i7748_xor_monitor.sv
// Bench for i7748_xor_monitor: vector table through a scoreboard queue, plus
// hand sequences for asynchronous reset and the RESET_VAL=1 variant.
// Inputs change on the falling edge; outputs are checked on the next falling edge.
module tb_i7748_xor_monitor;

   logic CK;
   logic reset;
   logic rst_b;

   int tests_run;
   int fail_count;

`ifdef I7748_SEQ_MON_EN
   localparam logic HIT = 1'b1;
`else
   localparam logic HIT = 1'b0;
`endif

   typedef struct {
      logic n0;
      logic n1;
      logic exp;
   } vec_t;

   localparam int NVEC = 29;
   vec_t vecs [NVEC];
   logic exp_q [$];

   i7748_xor_monitor_if bus_a ();
   i7748_xor_monitor_if bus_b ();

   i7748_xor_monitor #(.RESET_VAL(1'b0)) dut_a (
      .CK    (CK),
      .reset (reset),
      .bus   (bus_a.slave)
   );

   i7748_xor_monitor #(.RESET_VAL(1'b1)) dut_b (
      .CK    (CK),
      .reset (rst_b),
      .bus   (bus_b.slave)
   );

   initial begin
      CK = 1'b0;
      forever #10 CK = ~CK;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach its summary (time %0t)", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic act, input logic exp);
      tests_run++;
      if (act !== exp) begin
         fail_count++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic n0, input logic n1);
      bus_a.N0 = n0;
      bus_a.N1 = n1;
      bus_b.N0 = n0;
      bus_b.N1 = n1;
   endtask

   // Drive a code now, queue its expected result, and check after the next rising edge.
   task automatic step(input logic n0, input logic n1, input logic exp, input string name);
      logic e;
      drive(n0, n1);
      exp_q.push_back(exp);
      @(negedge CK);
      if (exp_q.size() == 0) begin
         tests_run++;
         fail_count++;
         $display("FAIL %s: scoreboard empty, got %b", name, bus_a.output_single);
      end else begin
         e = exp_q.pop_front();
         check(name, bus_a.output_single, e);
         check({name, "_rv1"}, bus_b.output_single, e);
      end
   endtask

   initial begin
      tests_run  = 0;
      fail_count = 0;

      // Continuous code stream after reset; expected output after each edge.
      vecs[0]  = '{1'b0, 1'b0, 1'b0};   // first edge after reset, 00 -> 0
      vecs[1]  = '{1'b0, 1'b1, 1'b1};   // 01 -> 1
      vecs[2]  = '{1'b0, 1'b0, 1'b0};   // 00 -> 0
      vecs[3]  = '{1'b1, 1'b0, 1'b1};   // 10 -> 1 (S1 broken, back to IDLE)
      vecs[4]  = '{1'b1, 1'b1, 1'b0};   // 11 -> 0, no hit
      vecs[5]  = '{1'b0, 1'b0, 1'b0};   // full sequence begins
      vecs[6]  = '{1'b0, 1'b1, 1'b1};
      vecs[7]  = '{1'b1, 1'b0, 1'b1};
      vecs[8]  = '{1'b1, 1'b1, HIT};    // hit pulse when monitor present
      vecs[9]  = '{1'b1, 1'b1, 1'b0};   // repeated 11: no new hit
      vecs[10] = '{1'b0, 1'b0, 1'b0};   // 00 twice stays in S1
      vecs[11] = '{1'b0, 1'b0, 1'b0};
      vecs[12] = '{1'b0, 1'b1, 1'b1};
      vecs[13] = '{1'b1, 1'b0, 1'b1};
      vecs[14] = '{1'b1, 1'b1, HIT};
      vecs[15] = '{1'b0, 1'b0, 1'b0};   // S3 interrupted by 00 restarts the sequence
      vecs[16] = '{1'b0, 1'b1, 1'b1};
      vecs[17] = '{1'b1, 1'b0, 1'b1};
      vecs[18] = '{1'b0, 1'b0, 1'b0};
      vecs[19] = '{1'b0, 1'b1, 1'b1};
      vecs[20] = '{1'b1, 1'b0, 1'b1};
      vecs[21] = '{1'b1, 1'b1, HIT};
      vecs[22] = '{1'b0, 1'b0, 1'b0};   // S2 broken by 01
      vecs[23] = '{1'b0, 1'b1, 1'b1};
      vecs[24] = '{1'b0, 1'b1, 1'b1};
      vecs[25] = '{1'b1, 1'b0, 1'b1};
      vecs[26] = '{1'b1, 1'b1, 1'b0};
      vecs[27] = '{1'b0, 1'b1, 1'b1};   // constant code holds the output
      vecs[28] = '{1'b0, 1'b1, 1'b1};

      // Reset phase: asserted for the first 5 ns with code 00.
      reset = 1'b1;
      rst_b = 1'b1;
      drive(1'b0, 1'b0);
      #2;
      check("reset_out", bus_a.output_single, 1'b0);
      check("reset_out_rv1", bus_b.output_single, 1'b1);
      #3;
      reset = 1'b0;
      rst_b = 1'b0;

      for (int i = 0; i < NVEC; i++) begin
         step(vecs[i].n0, vecs[i].n1, vecs[i].exp, $sformatf("vec%0d", i));
      end

      // Partial sequence then asynchronous reset between edges.
      step(1'b0, 1'b0, 1'b0, "mid_00");
      step(1'b0, 1'b1, 1'b1, "mid_01");
      step(1'b1, 1'b0, 1'b1, "mid_10");
      #3;
      reset = 1'b1;
      rst_b = 1'b1;
      #1;
      check("async_reset_drop", bus_a.output_single, 1'b0);
      check("async_reset_drop_rv1", bus_b.output_single, 1'b1);
      #2;
      reset = 1'b0;
      rst_b = 1'b0;
      step(1'b1, 1'b1, 1'b0, "after_reset_11");

      // RESET_VAL=1 instance: pulse its reset alone, then a 00 edge clears it.
      step(1'b0, 1'b1, 1'b1, "pre_rv1");
      #4;
      rst_b = 1'b1;
      #1;
      check("rv1_pulse", bus_b.output_single, 1'b1);
      check("rv0_unaffected", bus_a.output_single, 1'b1);
      #2;
      rst_b = 1'b0;
      step(1'b0, 1'b0, 1'b0, "rv1_first_00");

      if (exp_q.size() != 0) begin
         tests_run++;
         fail_count++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
      $finish;
   end

endmodule
